// File: rtl/mips_pkg.sv
// Shared definitions for the datapath helpers: the default data width and
// the state encoding of the serial set-less-than comparator.
package mips_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } cmp_state_t;

endpackage : mips_pkg

// File: rtl/slt_serial_compare.sv
// Serial set-less-than comparator. The operands are scanned MSB-first, one
// bit per cycle, and the scan stops at the first differing bit. Only the MSB
// position carries sign information. Below the MSB, the operand holding the 1
// is the larger one in both the signed and the unsigned case. All outputs are
// registered.
module slt_serial_compare
   import mips_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             lt
);

   localparam int IDX_W = $clog2(WIDTH);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);
   localparam logic [IDX_W-1:0] IDX_ZERO = '0;

   cmp_state_t       state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             sgn_q;
   logic [IDX_W-1:0] idx;

   // Control FSM, operand latches, scan index and the registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a_q   <= '0;
         b_q   <= '0;
         sgn_q <= 1'b0;
         idx   <= IDX_MAX;
         busy  <= 1'b0;
         done  <= 1'b0;
         lt    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_q   <= a;
                  b_q   <= b;
                  sgn_q <= is_signed;
                  idx   <= IDX_MAX;
                  lt    <= 1'b0;
                  busy  <= 1'b1;
                  state <= SCAN;
               end
            end
            SCAN: begin
               if (a_q[idx] != b_q[idx]) begin
                  // At the MSB of a signed compare, the operand with the
                  // sign bit set is the negative one, so it is the smaller.
                  if (idx == IDX_MAX && sgn_q) begin
                     lt <= a_q[idx];
                  end else begin
                     lt <= b_q[idx];
                  end
                  done  <= 1'b1;
                  state <= DONE;
               end else if (idx == IDX_ZERO) begin
                  lt    <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  idx <= idx - 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule : slt_serial_compare

// File: tb/tb_slt_serial_compare.sv
// Directed bench for the serial set-less-than comparator. It checks the
// result flag, the done-cycle latency, busy coverage, the start handshake and
// asynchronous reset behaviour.
module tb_slt_serial_compare;

   localparam int W = 32;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          is_signed;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          busy;
   logic          done;
   logic          lt;

   int checks = 0;
   int errors = 0;

   slt_serial_compare #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .is_signed (is_signed),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .lt        (lt)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at #1 after a clock edge, with busy low (this is cycle 0).
   // The task returns in the cycle after done, so a following call is
   // accepted at the earliest allowed cycle.
   task automatic run_compare(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                              input logic sv, input logic exp_lt, input int exp_cyc,
                              input bit hammer);
      int cyc;
      int done_cyc;
      int busy_bad;
      start     = 1'b1;
      a         = av;
      b         = bv;
      is_signed = sv;
      done_cyc  = -1;
      busy_bad  = 0;
      @(posedge clk); #1;
      cyc = 1;
      check({tag, " lt_clear"}, {31'd0, lt}, 32'd0);
      while (cyc <= W + 8) begin
         if (hammer) begin
            start     = 1'b1;
            a         = $urandom;
            b         = $urandom;
            is_signed = ~is_signed;
         end else begin
            start = 1'b0;
         end
         if (busy !== 1'b1) busy_bad++;
         if (done === 1'b1) begin
            done_cyc = cyc;
            break;
         end
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, " done_cycle"}, done_cyc, exp_cyc);
      check({tag, " lt"}, {31'd0, lt}, {31'd0, exp_lt});
      check({tag, " busy_span"}, busy_bad, 0);
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, " busy_after"}, {31'd0, busy}, 32'd0);
      check({tag, " done_after"}, {31'd0, done}, 32'd0);
      check({tag, " lt_hold"}, {31'd0, lt}, {31'd0, exp_lt});
      $display("txn %s a=%08h b=%08h signed=%0d lt=%0d done_cycle=%0d", tag, av, bv, sv, lt, done_cyc);
   endtask

   initial begin
      int done_seen;
      rst_n     = 1'b0;
      start     = 1'b0;
      is_signed = 1'b0;
      a         = '0;
      b         = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset lt", {31'd0, lt}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_compare("u_msb",     32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 2,  1'b0);
      run_compare("s_msb",     32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 2,  1'b0);
      run_compare("s_neg_pos", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 2,  1'b0);
      run_compare("u_neg_pos", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 2,  1'b0);
      run_compare("u_lsb",     32'h0000_0004, 32'h0000_0005, 1'b0, 1'b1, 33, 1'b0);
      run_compare("u_lsb_sw",  32'h0000_0005, 32'h0000_0004, 1'b0, 1'b0, 33, 1'b0);
      run_compare("u_equal",   32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 33, 1'b0);
      run_compare("s_equal",   32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 33, 1'b0);
      run_compare("s_both_neg",32'h8000_0000, 32'h8000_0001, 1'b1, 1'b1, 33, 1'b0);
      run_compare("s_mid",     32'h0001_0000, 32'h0000_FFFF, 1'b1, 1'b0, 17, 1'b0);

      // Handshake: start held high with changing operands during the whole
      // compare including the done cycle; then an immediate back-to-back accept.
      run_compare("hs_first",  32'h0000_0004, 32'h0000_0005, 1'b0, 1'b1, 33, 1'b1);
      run_compare("hs_next",   32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 2,  1'b0);

      // Asynchronous reset in IDLE with lt set: clears without a clock edge.
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_idle lt", {31'd0, lt}, 32'd0);
      check("arst_idle busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Asynchronous reset mid-SCAN: busy drops at once and no done follows.
      start     = 1'b1;
      is_signed = 1'b0;
      a         = 32'h0;
      b         = 32'h0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("mid_scan busy", {31'd0, busy}, 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_scan busy", {31'd0, busy}, 32'd0);
      check("arst_scan done", {31'd0, done}, 32'd0);
      check("arst_scan lt", {31'd0, lt}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) done_seen++;
      end
      check("arst_scan no_done", done_seen, 0);
      $display("txn arst_scan aborted compare done_or_busy_cycles=%0d", done_seen);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_slt_serial_compare
